mul_div_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit holding the architectural HI/LO registers for the pipelined MIPS-style CPU.
- Sits in EX beside the single-cycle ALU and covers the operations the ALU does not: mult, multu, div, divu, mthi, mtlo.
- The hazard unit stalls the pipeline on busy. mfhi/mflo read the hi/lo outputs directly.

---
 rtl/mul_div_if.sv | 26 ++
 rtl/mul_div_unit.sv | 166 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_if.sv
// Handshake and HI/LO bundle between the EX stage and the multiply/divide unit.
interface mul_div_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Operands are reduced to magnitudes at launch; signs are restored when the result is written.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  mul_div_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  // acc: product upper half / partial remainder; sh: multiplier / dividend-quotient shifter
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic             div_q, div_d;
  logic             sa_q, sa_d;       // first operand negative (signed ops only)
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             sgn_in, sa_in, sb_in;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_rem;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: WIDTH steps in StRun, then one write-back cycle in StFin
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.start) state_d = StRun;
      StRun:  if (cnt_q == CntW'(WIDTH - 1)) state_d = StFin;
      StFin:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy = (state_q != StIdle);
  end

  // Operand conditioning, one iteration step and the final sign fixup
  always_comb begin
    sgn_in = ~bus.op[0];
    sa_in  = sgn_in & bus.a[WIDTH-1];
    sb_in  = sgn_in & bus.b[WIDTH-1];
    // -0x80000000 wraps to 0x80000000, which read unsigned is the correct magnitude
    mag_a  = sa_in ? -bus.a : bus.a;
    mag_b  = sb_in ? -bus.b : bus.b;

    mul_sum   = {1'b0, acc_q} + {1'b0, (sh_q[0] ? opnd_q : {WIDTH{1'b0}})};
    div_shift = {acc_q, sh_q[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, opnd_q});
    // Only used when div_ok, where the true difference is below 2^WIDTH
    div_rem   = div_shift[WIDTH-1:0] - opnd_q;

    prod     = {acc_q, sh_q};
    prod_fix = (sa_q ^ sb_q) ? -prod : prod;
    quo_fix  = (sa_q ^ sb_q) ? -sh_q : sh_q;
    rem_fix  = sa_q ? -acc_q : acc_q;
  end

  // Datapath and HI/LO next state
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    sh_d   = sh_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.mthi) hi_d = bus.wdata;
        if (bus.mtlo) lo_d = bus.wdata;
        if (bus.start) begin
          cnt_d  = '0;
          acc_d  = '0;
          div_d  = bus.op[1];
          sa_d   = sa_in;
          sb_d   = sb_in;
          sh_d   = bus.op[1] ? mag_a : mag_b;
          opnd_d = bus.op[1] ? mag_b : mag_a;
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        if (div_q) begin
          acc_d = div_ok ? div_rem : div_shift[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], div_ok};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
        end
      end
      StFin: begin
        done_d = 1'b1;
        if (div_q) begin
          // Zero divisor: every trial subtract succeeds, so the remainder is the dividend
          lo_d = (opnd_q == '0) ? {WIDTH{1'b1}} : quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  // Datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      sh_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, corner sequences and random ops
// compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;

  mul_div_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {hi, lo} from the architectural definition using 64-bit arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint          sx, sy, q, m;
    longint unsigned ux, uy, uq, um;
    logic [63:0]     r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    r  = '0;
    case (o)
      2'd0: r = sx * sy;
      2'd1: r = ux * uy;
      2'd2: begin
        if (y == 32'd0) begin
          r = {x, 32'hFFFF_FFFF};
        end else begin
          q = sx / sy;
          m = sx % sy;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) begin
          r = {x, 32'hFFFF_FFFF};
        end else begin
          uq = ux / uy;
          um = ux % uy;
          r = {um[31:0], uq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Launch from idle at #1 after an edge; returns at #1 after the edge where done rose.
  task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                        output logic [31:0] rhi, output logic [31:0] rlo,
                        output int lat, output int busy_bad);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = va;
    bus.b     = vb;
    tick();
    bus.start = 1'b0;
    // Operands must have been latched; scramble the live inputs
    bus.a     = $urandom;
    bus.b     = $urandom;
    lat       = 0;
    busy_bad  = 0;
    while (bus.done !== 1'b1 && lat < 60) begin
      if (bus.busy !== 1'b1) busy_bad++;
      tick();
      lat++;
    end
    if (bus.busy !== 1'b0) busy_bad++;
    rhi = bus.hi;
    rlo = bus.lo;
  endtask

  initial begin
    logic [31:0] rhi, rlo, mhi, mlo, va, vb, wd;
    logic [1:0]  o;
    logic [63:0] exp;
    logic        dh, dl;
    int          lat, busy_bad, n_done, n_busy;

    vecs[0] = '{op: 2'd1, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, hi: 32'hFFFF_FFFE, lo: 32'h0000_0001};
    vecs[1] = '{op: 2'd0, a: 32'hFFFF_FFFD, b: 32'h0000_0007, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB};
    vecs[2] = '{op: 2'd0, a: 32'h8000_0000, b: 32'h8000_0000, hi: 32'h4000_0000, lo: 32'h0000_0000};
    vecs[3] = '{op: 2'd2, a: 32'hFFFF_FFF9, b: 32'h0000_0002, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD};
    vecs[4] = '{op: 2'd3, a: 32'hFFFF_FFF9, b: 32'h0000_0002, hi: 32'h0000_0001, lo: 32'h7FFF_FFFC};
    vecs[5] = '{op: 2'd2, a: 32'h8000_0000, b: 32'hFFFF_FFFF, hi: 32'h0000_0000, lo: 32'h8000_0000};
    vecs[6] = '{op: 2'd3, a: 32'h0000_0064, b: 32'h0000_0000, hi: 32'h0000_0064, lo: 32'hFFFF_FFFF};
    vecs[7] = '{op: 2'd2, a: 32'hFFFF_FFFB, b: 32'h0000_0000, hi: 32'hFFFF_FFFB, lo: 32'hFFFF_FFFF};
    vecs[8] = '{op: 2'd0, a: 32'h0000_0007, b: 32'hFFFF_FFFE, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF2};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = '0;
    bus.b     = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, rhi, rlo, lat, busy_bad);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
      check($sformatf("vec%0d_busy", i), 64'(busy_bad), 64'd0);
      check($sformatf("vec%0d_hilo", i), {rhi, rlo}, {vecs[i].hi, vecs[i].lo});
      tick();
      check($sformatf("vec%0d_done_pulse", i), 64'(bus.done), 64'd0);
    end
    mhi = vecs[8].hi;

    // start and mthi while busy are ignored
    bus.start = 1'b1;
    bus.op    = 2'd1;
    bus.a     = 32'd5;
    bus.b     = 32'd6;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.start = 1'b1;
    bus.op    = 2'd3;
    bus.a     = 32'h999;
    bus.b     = 32'd3;
    bus.mthi  = 1'b1;
    bus.wdata = 32'h1234;
    tick();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    check("busy_mthi_ignored", 64'(bus.hi), 64'(mhi));
    lat = 10;
    while (bus.done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    check("ignore_latency", 64'(lat), 64'd33);
    check("ignore_hilo", {bus.hi, bus.lo}, {32'd0, 32'd30});
    n_done = 1;
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) n_done++;
      if (bus.busy !== 1'b0) n_busy++;
    end
    check("ignore_done_count", 64'(n_done), 64'd1);
    check("ignore_no_queue", 64'(n_busy), 64'd0);

    // Reset mid-operation aborts cleanly
    bus.start = 1'b1;
    bus.op    = 2'd2;
    bus.a     = 32'hFFFF_FFF9;
    bus.b     = 32'd2;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) n_done++;
      if (bus.busy !== 1'b0) n_busy++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);
    check("abort_stays_idle", 64'(n_busy), 64'd0);
    bus.mtlo  = 1'b1;
    bus.wdata = 32'hABCD;
    tick();
    bus.mtlo  = 1'b0;
    check("mtlo_after_abort", {bus.hi, bus.lo}, {32'd0, 32'hABCD});

    // Move and start in the same idle cycle: move lands now, result overwrites at the end
    bus.start = 1'b1;
    bus.op    = 2'd1;
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h5555;
    tick();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    check("move_with_start", {bus.hi, bus.lo}, {32'h5555, 32'h5555});
    lat = 0;
    while (bus.done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    check("move_start_latency", 64'(lat), 64'd33);
    check("move_start_result", {bus.hi, bus.lo}, {32'd0, 32'd6});
    tick();
    mhi = 32'd0;
    mlo = 32'd6;

    // Random ops and moves against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        dh = 1'($urandom_range(0, 1));
        dl = 1'($urandom_range(0, 1));
        wd = $urandom;
        bus.mthi  = dh;
        bus.mtlo  = dl;
        bus.wdata = wd;
        tick();
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        if (dh) mhi = wd;
        if (dl) mlo = wd;
        check($sformatf("rand%0d_move", i), {bus.hi, bus.lo}, {mhi, mlo});
      end
      o  = 2'($urandom_range(0, 3));
      va = pick_operand();
      vb = pick_operand();
      exp = model(o, va, vb);
      run_op(o, va, vb, rhi, rlo, lat, busy_bad);
      check($sformatf("rand%0d_op%0d_%h_%h", i, o, va, vb), {rhi, rlo}, exp);
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'd33);
      mhi = exp[63:32];
      mlo = exp[31:0];
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
